fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the single-cycle RISC-V core. It holds the architectural PC and issues word requests to instruction memory over a req/ack handshake. It presents the fetched instruction to the decode/control stage with a valid/ready handshake; `instr[6:0]` drives the control decoder's opcode input. On each accepted instruction it computes the next PC from the decoder's 2-bit PC-source select plus the branch condition, immediate and rs1 returned by the datapath.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; must be word aligned.
- `NOP_INSTR`, 32'h0000_0013, value driven on `instr` while no valid instruction is held (addi x0,x0,0).

Ports:
- `clk`  in  1  rising-edge clock.
- `n_rst`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  byte address of the requested word (= `pc`).
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `instr`  out  32  held instruction to decode.
- `instr_valid`  out  1  `instr`/`pc` are valid.
- `instr_ready`  in  1  decode/execute consumes the instruction this cycle.
- `pc`  out  32  address of the instruction in `instr`.
- `pc_src`  in  2  00: PC+4; 01: conditional branch; 10: jump register (rs1+imm); 11: reserved, treated as 00.
- `branch_cond`  in  1  branch outcome, used only when `pc_src`=01.
- `imm`  in  32  sign-extended immediate from the immediate generator.
- `rs1`  in  32  register-file read data 1.
- `fault`  out  1  sticky misaligned-target fault.

## Operation
- States: IDLE, FETCH, HOLD, HALT.
- `imem_req` = (state==FETCH). `instr_valid` = (state==HOLD). `imem_addr` = `pc`.
- IDLE:
  - Entered only by reset.
  - Goes to FETCH unconditionally on the next edge.
- FETCH:
  - `imem_req` and `imem_addr` are held stable until `imem_ack`=1.
  - On an edge with `imem_ack`=1: `instr` <= `imem_rdata`, go to HOLD.
  - `imem_ack` is ignored in every other state.
- HOLD:
  - `instr` and `pc` are held stable while `instr_ready`=0.
  - On an edge with `instr_ready`=1, the instruction is accepted and `next_pc` is computed from that same cycle's `pc_src`, `branch_cond`, `imm` and `rs1`:
    - 00/11: `pc`+4.
    - 01: `branch_cond` ? `pc`+`imm` : `pc`+4.
    - 10: (`rs1`+`imm`) & 32'hFFFF_FFFE.
  - All additions are modulo 2^32, with no overflow detection. `pc`=32'hFFFF_FFFC plus 4 wraps to 0.
  - If `next_pc[1:0]`==00: `pc` <= `next_pc`, `instr` <= `NOP_INSTR`, go to FETCH.
  - Otherwise: `pc` <= `next_pc`, `fault` <= 1, `instr` <= `NOP_INSTR`, go to HALT.
- HALT:
  - No requests are issued and `instr_valid`=0.
  - `pc` shows the faulting target.
  - Left only by reset.
- Reset (async, any state, including mid-FETCH with an outstanding request):
  - Outputs: `pc`=`RESET_PC`, `instr`=`NOP_INSTR`, `fault`=0, state=IDLE, hence `imem_req`=0 and `instr_valid`=0.
  - An `imem_ack` arriving after reset, for the abandoned request, is ignored.

## Timing
- All state, `pc`, `instr` and `fault` are registered. `imem_req`/`instr_valid` decode state only; no combinational path runs from inputs to them.
- Memory ack may arrive in the same cycle as the request (zero-wait) or any number of cycles later.
- Minimum throughput is one instruction per 2 cycles:
  - cycle N: FETCH with `imem_ack`=1;
  - cycle N+1: HOLD with `instr_ready`=1;
  - cycle N+2: FETCH at `next_pc`.
- The first request appears on the 1st cycle after the first rising edge following `n_rst` deassertion (IDLE lasts exactly one cycle).
- `pc_src`, `branch_cond`, `imm` and `rs1` are sampled only on the accepting edge and may change freely otherwise.
- Each `k` cycles of ack wait adds `k` cycles, and each cycle of `instr_ready`=0 adds one cycle.

## Test plan
- Reset/boot: hold `n_rst`=0 → `imem_req`=0, `instr_valid`=0, `instr`=32'h13, `pc`=0. Release → IDLE one cycle, then `imem_req`=1, `imem_addr`=0.
- Sequential fetch with zero-wait ack and `instr_ready`=1, `pc_src`=00: addresses 0,4,8,C on every other cycle. Repeat with 3-cycle ack latency: `imem_addr` is stable for 4 cycles per fetch.
- Branches at `pc`=0x40, `imm`=0xFFFF_FFF0:
  - `pc_src`=01, `branch_cond`=1 → next fetch 0x30.
  - `branch_cond`=0 → 0x44.
  - `pc_src`=11 → 0x44.
- JALR: `pc_src`=10, `rs1`=0x101, `imm`=7 → next `pc`=0x108 (bit0 cleared). With `rs1`=0x102, `imm`=0 → `fault`=1, `pc`=0x102, no further `imem_req` until reset.
- Back-pressure: `instr_ready`=0 for 5 cycles in HOLD → `instr`/`pc` unchanged, `imem_req`=0. Change `pc_src`/`imm` during the stall → no effect until the accepting edge.
- Reset mid-operation: assert `n_rst` during FETCH at `pc`=0x20 with ack pending → outputs return to reset values immediately. A late `imem_ack` is ignored, and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over req/ack and
// hands them to decode over valid/ready, resolving the next PC on accept.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        n_rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic        branch_cond,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    HALT
  } state_t;

  state_t      state;
  logic [31:0] next_pc;
  logic [31:0] pc_inc;
  logic [31:0] pc_br;
  logic [31:0] jr_tgt;

  assign imem_req    = (state == FETCH);
  assign instr_valid = (state == HOLD);
  assign imem_addr   = pc;

  assign pc_inc = pc + 32'd4;
  assign pc_br  = pc + imm;
  assign jr_tgt = (rs1 + imm) & 32'hFFFF_FFFE;

  // Reserved select 11 falls back to sequential flow.
  always_comb begin
    next_pc = pc_inc;
    unique case (1'b1)
      (pc_src == 2'b01): next_pc = branch_cond ? pc_br : pc_inc;
      (pc_src == 2'b10): next_pc = jr_tgt;
      default:           next_pc = pc_inc;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      instr <= NOP_INSTR;
      fault <= 1'b0;
    end else begin
      unique case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            instr <= imem_rdata;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            pc    <= next_pc;
            instr <= NOP_INSTR;
            if (next_pc[1:0] == 2'b00) begin
              state <= FETCH;
            end else begin
              fault <= 1'b1;
              state <= HALT;
            end
          end
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a scripted memory/consumer pair
// with an independent next-PC model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic [1:0]  pc_src;
  logic        branch_cond;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        fault;

  fetch_unit dut (
    .clk(clk),
    .n_rst(n_rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instr(instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .pc(pc),
    .pc_src(pc_src),
    .branch_cond(branch_cond),
    .imm(imm),
    .rs1(rs1),
    .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } item_t;

  item_t       sb[$];
  logic [31:0] exp_pc;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0000_1003;
  endfunction

  function automatic logic [31:0] model_next(
    input logic [31:0] p,
    input logic [1:0]  src,
    input logic        c,
    input logic [31:0] im,
    input logic [31:0] r
  );
    case (src)
      2'b01:   return c ? p + im : p + 32'd4;
      2'b10:   return (r + im) & 32'hFFFF_FFFE;
      default: return p + 32'd4;
    endcase
  endfunction

  task automatic scramble();
    pc_src      = 2'($urandom);
    branch_cond = 1'($urandom);
    imm         = $urandom;
    rs1         = $urandom;
  endtask

  // Called at a negedge with the DUT in FETCH at exp_pc.
  task automatic step(input int k, input int d,
                      input logic [1:0]  src,
                      input logic        c,
                      input logic [31:0] im,
                      input logic [31:0] r);
    item_t       it;
    logic [31:0] nxt;
    chk("req", 32'(imem_req), 32'd1);
    chk("addr", imem_addr, exp_pc);
    for (int i = 0; i < k; i++) begin
      imem_ack = 1'b0;
      @(negedge clk);
      chk("req_wait", 32'(imem_req), 32'd1);
      chk("addr_wait", imem_addr, exp_pc);
      chk("valid_wait", 32'(instr_valid), 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = mem(exp_pc);
    sb.push_back('{pc: exp_pc, ins: mem(exp_pc)});
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    for (int i = 0; i < d; i++) begin
      instr_ready = 1'b0;
      scramble();
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_req", 32'(imem_req), 32'd0);
      if (sb.size() > 0) begin
        chk("stall_instr", instr, sb[0].ins);
        chk("stall_pc", pc, sb[0].pc);
      end
      @(negedge clk);
    end
    chk("valid", 32'(instr_valid), 32'd1);
    pc_src      = src;
    branch_cond = c;
    imm         = im;
    rs1         = r;
    instr_ready = 1'b1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty got 0 exp 1");
    end else begin
      it = sb.pop_front();
      chk("instr", instr, it.ins);
      chk("pc", pc, it.pc);
    end
    nxt    = model_next(exp_pc, src, c, im, r);
    exp_pc = nxt;
    @(negedge clk);
    instr_ready = 1'b0;
    scramble();
    chk("nop", instr, NOP);
    chk("pc_next", pc, nxt);
    chk("valid_after", 32'(instr_valid), 32'd0);
    if (nxt[1:0] == 2'b00) begin
      chk("no_fault", 32'(fault), 32'd0);
    end else begin
      chk("fault", 32'(fault), 32'd1);
      for (int i = 0; i < 4; i++) begin
        imem_ack = 1'b1;
        @(negedge clk);
        chk("halt_req", 32'(imem_req), 32'd0);
        chk("halt_valid", 32'(instr_valid), 32'd0);
        chk("halt_pc", pc, nxt);
      end
      imem_ack = 1'b0;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instr"}, instr, NOP);
    chk({tag, "_pc"}, pc, 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
  endtask

  task automatic boot();
    n_rst = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    n_rst = 1'b1;
    #1;
    chk("idle_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    exp_pc = 32'd0;
  endtask

  initial begin
    n_rst       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    pc_src      = 2'b00;
    branch_cond = 1'b0;
    imm         = '0;
    rs1         = '0;
    exp_pc      = '0;
    boot();

    repeat (3) step(0, 0, 2'b00, 1'b0, 32'd0, 32'd0);
    repeat (2) step(3, 0, 2'b00, 1'b0, 32'd0, 32'd0);

    step(0, 0, 2'b10, 1'b0, 32'd0, 32'h40);
    step(0, 0, 2'b01, 1'b1, 32'hFFFF_FFF0, 32'd0);
    step(0, 0, 2'b10, 1'b0, 32'd0, 32'h40);
    step(0, 5, 2'b01, 1'b0, 32'hFFFF_FFF0, 32'd0);
    step(0, 0, 2'b10, 1'b0, 32'd0, 32'h40);
    step(0, 0, 2'b11, 1'b1, 32'hFFFF_FFF0, 32'd0);
    step(1, 0, 2'b10, 1'b0, 32'd7, 32'h101);
    step(0, 0, 2'b10, 1'b0, 32'd0, 32'hFFFF_FFFC);
    step(0, 0, 2'b00, 1'b0, 32'd0, 32'd0);
    step(0, 0, 2'b10, 1'b0, 32'd0, 32'h20);

    chk("mid_req", 32'(imem_req), 32'd1);
    chk("mid_addr", imem_addr, 32'h20);
    imem_ack = 1'b0;
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check_reset_vals("mid");
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_valid", 32'(instr_valid), 32'd0);
    chk("late_ack_instr", instr, NOP);
    sb.delete();
    exp_pc = 32'd0;
    repeat (2) step(0, 0, 2'b00, 1'b0, 32'd0, 32'd0);

    step(2, 0, 2'b10, 1'b0, 32'd0, 32'h102);

    boot();
    step(0, 0, 2'b00, 1'b0, 32'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
